// File: rtl/dump_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dump_pkg
// Description : Shared types and constants for the state dump sequencer:
//               FSM state encoding, stream item tags and end-marker layout.
// Revision    : 1.0 - initial release
// ============================================================================
package dump_pkg;

    // Sequencer states, explicitly 3 bits wide
    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_DUMP_REG = 3'd1,
        ST_DUMP_MEM = 3'd2,
        ST_END      = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Stream field widths
    localparam int TAG_W   = 2;
    localparam int INDEX_W = 16;
    localparam int DATA_W  = 32;

    // Item type tags; 0 is never emitted
    localparam logic [TAG_W-1:0] TAG_REG = 2'd1;
    localparam logic [TAG_W-1:0] TAG_MEM = 2'd2;
    localparam logic [TAG_W-1:0] TAG_END = 2'd3;

    // End-marker field positions
    localparam int END_ZERO_BIT    = 31;
    localparam int END_TIMEOUT_BIT = 30;
    localparam int END_CNT_LSB     = 0;
    localparam int END_CNT_W       = 16;

    // Builds the end-marker payload from the halt cause bits and halt cycle
    function automatic logic [DATA_W-1:0] end_marker(
        input logic                 zero_inst,
        input logic                 timeout,
        input logic [END_CNT_W-1:0] cnt
    );
        logic [DATA_W-1:0] v;
        v                                    = '0;
        v[END_ZERO_BIT]                      = zero_inst;
        v[END_TIMEOUT_BIT]                   = timeout;
        v[END_CNT_LSB +: END_CNT_W]          = cnt;
        return v;
    endfunction

endpackage : dump_pkg
`default_nettype wire

// File: rtl/stream_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : stream_out_reg
// Description : Single-entry valid/ready output register. Holds tag, index
//               and data stable while the consumer stalls; accepts a new item
//               whenever the slot is empty or being drained this cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_out_reg
    import dump_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_ready,
    input  logic [TAG_W-1:0]   i_tag,
    input  logic [INDEX_W-1:0] i_index,
    input  logic [DATA_W-1:0]  i_data,
    output logic               o_can_load,
    output logic               o_valid,
    output logic [TAG_W-1:0]   o_tag,
    output logic [INDEX_W-1:0] o_index,
    output logic [DATA_W-1:0]  o_data
);

    logic               r_valid;
    logic [TAG_W-1:0]   r_tag;
    logic [INDEX_W-1:0] r_index;
    logic [DATA_W-1:0]  r_data;

    // Slot is free when empty or when the current item is accepted this edge
    assign o_can_load = !r_valid || i_ready;

    // Output register: load a new item, otherwise drop valid once accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_index <= '0;
            r_data  <= '0;
        end else if (i_load && o_can_load) begin
            r_valid <= 1'b1;
            r_tag   <= i_tag;
            r_index <= i_index;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_tag   = r_tag;
    assign o_index = r_index;
    assign o_data  = r_data;

endmodule : stream_out_reg
`default_nettype wire

// File: rtl/state_dump_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : state_dump_sequencer
// Description : Detects end of program (zero instruction or cycle budget),
//               freezes the machine, then streams the register file, a data
//               memory window and a final end marker over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module state_dump_sequencer
    import dump_pkg::*;
#(
    parameter int unsigned MAX_CYCLES = 64,
    parameter int unsigned NUM_REGS   = 32,
    parameter logic [31:0] MEM_BASE   = 32'h4000,
    parameter int unsigned MEM_COUNT  = 4
)(
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         inst,
    output logic                halt_req,
    output logic [4:0]          rf_raddr,
    input  logic [31:0]         rf_rdata,
    output logic [31:0]         mem_raddr,
    input  logic [7:0]          mem_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [TAG_W-1:0]    out_tag,
    output logic [INDEX_W-1:0]  out_index,
    output logic [DATA_W-1:0]   out_data,
    output logic                done
);

    localparam logic [31:0]        c_max_cycles = 32'(MAX_CYCLES);
    localparam logic [31:0]        c_last_cycle = 32'(MAX_CYCLES - 1);
    localparam logic [INDEX_W-1:0] c_last_reg   = INDEX_W'(NUM_REGS - 1);
    localparam logic [INDEX_W-1:0] c_last_mem   = INDEX_W'(MEM_COUNT - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [31:0]        r_cycle_cnt;
    logic [INDEX_W-1:0] r_item_cnt;
    logic               r_zero_inst;
    logic               r_timeout;
    logic               r_halt_req;
    logic               r_done;

    logic               w_zero_inst;
    logic               w_timeout;
    logic               w_halt;
    logic               w_load;
    logic               w_can_load;
    logic               w_last_item;
    logic [TAG_W-1:0]   w_tag;
    logic [INDEX_W-1:0] w_index;
    logic [DATA_W-1:0]  w_data;

    assign w_zero_inst = (inst == 32'd0);
    assign w_timeout   = (r_cycle_cnt == c_last_cycle);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, read-port addressing and the item offered to the output slot
    always_comb begin
        w_next_state = r_state;
        w_halt       = 1'b0;
        w_load       = 1'b0;
        w_last_item  = 1'b0;
        w_tag        = '0;
        w_index      = '0;
        w_data       = '0;
        rf_raddr     = '0;
        mem_raddr    = MEM_BASE;
        case (r_state)
            ST_RUN: begin
                w_halt = w_zero_inst || w_timeout;
                if (w_halt) begin
                    w_next_state = ST_DUMP_REG;
                end
            end
            ST_DUMP_REG: begin
                rf_raddr    = r_item_cnt[4:0];
                w_load      = w_can_load;
                w_tag       = TAG_REG;
                w_index     = r_item_cnt;
                w_data      = rf_rdata;
                w_last_item = (r_item_cnt == c_last_reg);
                if (w_load && w_last_item) begin
                    w_next_state = ST_DUMP_MEM;
                end
            end
            ST_DUMP_MEM: begin
                mem_raddr   = MEM_BASE + {16'd0, r_item_cnt};
                w_load      = w_can_load;
                w_tag       = TAG_MEM;
                w_index     = r_item_cnt;
                w_data      = {24'd0, mem_rdata};
                w_last_item = (r_item_cnt == c_last_mem);
                if (w_load && w_last_item) begin
                    w_next_state = ST_END;
                end
            end
            ST_END: begin
                w_load      = w_can_load;
                w_tag       = TAG_END;
                w_index     = '0;
                w_data      = end_marker(r_zero_inst, r_timeout, r_cycle_cnt[15:0]);
                w_last_item = 1'b1;
                if (w_load) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_DONE;
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase
    end

    // Cycle budget, halt cause capture, item counter and completion flag.
    // The cycle counter stops at detection so the end marker reports that value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_cnt <= '0;
            r_item_cnt  <= '0;
            r_zero_inst <= 1'b0;
            r_timeout   <= 1'b0;
            r_halt_req  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if ((r_state == ST_RUN) && !w_halt && (r_cycle_cnt != c_max_cycles)) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
            if (w_halt) begin
                r_halt_req  <= 1'b1;
                r_zero_inst <= w_zero_inst;
                r_timeout   <= w_timeout;
            end
            if (w_load) begin
                r_item_cnt <= w_last_item ? '0 : r_item_cnt + INDEX_W'(1);
            end
            if ((r_state == ST_DONE) && out_valid && out_ready) begin
                r_done <= 1'b1;
            end
        end
    end

    assign halt_req = r_halt_req;
    assign done     = r_done;

    stream_out_reg u_stream_out_reg (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_load),
        .i_ready    (out_ready),
        .i_tag      (w_tag),
        .i_index    (w_index),
        .i_data     (w_data),
        .o_can_load (w_can_load),
        .o_valid    (out_valid),
        .o_tag      (out_tag),
        .o_index    (out_index),
        .o_data     (out_data)
    );

endmodule : state_dump_sequencer
`default_nettype wire
